// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for seq_alu.
// Latency and backpressure: none, this file holds declarations only.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDC = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } state_t;

  localparam int FLG_C = 0;
  localparam int FLG_V = 1;
  localparam int FLG_N = 2;
  localparam int FLG_Z = 3;
  localparam int NFLG  = 4;

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 Booth signed multiplier, one iteration per cycle; fin pulses WIDTH cycles after load.
// No backpressure: a load restarts it, and the product holds until the next load.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   product,
  output logic                 fin
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // The accumulator has one extra bit, so subtracting the most negative multiplicand cannot wrap.
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   mcand;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic             run;
  logic [CW-1:0]    cnt;

  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      run   <= 1'b0;
      cnt   <= '0;
      fin   <= 1'b0;
    end else if (load) begin
      acc   <= '0;
      mcand <= {A[WIDTH-1], A};
      q     <= B;
      q_1   <= 1'b0;
      run   <= 1'b1;
      cnt   <= '0;
      fin   <= 1'b0;
    end else if (run) begin
      // Arithmetic right shift of {sum, q, q_1}
      acc <= {sum[WIDTH], sum[WIDTH:1]};
      q   <= {sum[0], q[WIDTH-1:1]};
      q_1 <= q[0];
      cnt <= cnt + CW'(1);
      if (cnt == LAST) begin
        run <= 1'b0;
        fin <= 1'b1;
      end else begin
        fin <= 1'b0;
      end
    end else begin
      fin <= 1'b0;
    end
  end

  assign product = {acc[WIDTH-1:0], q};

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with start/busy/done handshake; 1 cycle to done, WIDTH+1 cycles for MUL.
// No queueing: start is ignored while busy, and results hold until the next done.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] w,
  output logic             cout,
  output logic             ovf,
  output logic             neg,
  output logic             zer
);

  state_t             state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               c_q;
  logic [NFLG-1:0]    flg_q;

  logic [2*WIDTH-1:0] product;
  logic               mul_fin;
  logic               mul_load;

  logic [WIDTH-1:0]   opb;
  logic               cin;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shl;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               res_v;
  logic               commit;

  assign mul_load = (state == IDLE) && start && (opcode == OP_MUL);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .load   (mul_load),
    .A      (A),
    .B      (B),
    .product(product),
    .fin    (mul_fin)
  );

  // ADD, ADDC and SUB share one adder; SUB feeds ~B with carry-in 1.
  assign opb = (op_q == OP_SUB) ? ~b_q : b_q;

  always_comb begin
    cin = 1'b0;
    if (op_q == OP_ADDC) begin
      cin = c_q;
    end else if (op_q == OP_SUB) begin
      cin = 1'b1;
    end
  end

  assign sum = {1'b0, a_q} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
  // The bit landing in position WIDTH is the last one shifted out.
  assign shl = {1'b0, a_q} << b_q[SHW-1:0];

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op_q)
      OP_ADD, OP_ADDC, OP_SUB: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (a_q[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_SHL: begin
        res   = shl[WIDTH-1:0];
        res_c = shl[WIDTH];
      end
      OP_MUL: begin
        res   = product[WIDTH-1:0];
        res_v = product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}};
      end
    endcase
  end

  assign commit = (state == EXEC) || ((state == MUL) && mul_fin);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      w     <= '0;
      flg_q <= '0;
    end else begin
      done <= 1'b0;
      if (commit) begin
        w            <= res;
        flg_q[FLG_C] <= res_c;
        flg_q[FLG_V] <= res_v;
        flg_q[FLG_N] <= res[WIDTH-1];
        flg_q[FLG_Z] <= (res == '0);
        done         <= 1'b1;
        busy         <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= opcode;
            a_q   <= A;
            b_q   <= B;
            c_q   <= carry;
            busy  <= 1'b1;
            state <= (opcode == OP_MUL) ? MUL : EXEC;
          end
        end
        EXEC:    state <= IDLE;
        MUL:     if (mul_fin) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cout = flg_q[FLG_C];
  assign ovf  = flg_q[FLG_V];
  assign neg  = flg_q[FLG_N];
  assign zer  = flg_q[FLG_Z];

endmodule
